// File: rtl/fir_mac_sequencer_pkg.sv
// Shared core constants for the FIR MAC sequencer: ALU opcodes/control codes
// as decoded by the execute-stage ALU, plus the sequencer FSM encoding.
package fir_mac_sequencer_pkg;

    localparam logic [4:0] ALU_OP_ADD      = 5'd0;
    localparam logic [4:0] ALU_OP_VMAC     = 5'd20;
    localparam logic [2:0] ALU_CTRL_NOJUMP = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fir_mac_sequencer.sv
// Sequences the shared ALU through one FIR output: one VMAC per tap over a
// circular delay line and a coefficient bank, accumulating the ALU result.
module fir_mac_sequencer
    import fir_mac_sequencer_pkg::*;
#(
    parameter int TAPS   = 8,
    parameter int ADDR_W = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       sampleIn,
    input  logic              coeffWe,
    input  logic [ADDR_W-1:0] coeffAddr,
    input  logic [31:0]       coeffData,
    input  logic [31:0]       aluResult,
    output logic [31:0]       aluIn1,
    output logic [31:0]       aluIn2,
    output logic [31:0]       aluAccum,
    output logic [4:0]        aluOperation,
    output logic [2:0]        aluControl,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(TAPS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] head_q;
    logic [ADDR_W-1:0] k_q;
    logic [31:0]       acc_q;
    logic [31:0]       sample_q;
    logic [31:0]       result_q;
    logic [31:0]       delay_q [TAPS];
    logic [31:0]       coef_q  [TAPS];
    logic              in_mac;
    logic [ADDR_W-1:0] tap_idx;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_MAC;
            ST_MAC:  if (k_q == K_LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Newest sample sits at head, so tap k reads k positions behind it.
    assign tap_idx = head_q - k_q;
    assign in_mac  = (state_q == ST_MAC);

    assign aluIn1       = in_mac ? coef_q[k_q]      : 32'd0;
    assign aluIn2       = in_mac ? delay_q[tap_idx] : 32'd0;
    assign aluAccum     = in_mac ? acc_q            : 32'd0;
    assign aluOperation = in_mac ? ALU_OP_VMAC      : ALU_OP_ADD;
    assign aluControl   = ALU_CTRL_NOJUMP;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign result       = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            head_q   <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            result_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (coeffWe) coef_q[coeffAddr] <= coeffData;
                    if (start)   sample_q <= sampleIn;
                end
                ST_LOAD: begin
                    delay_q[head_q] <= sample_q;
                    acc_q           <= '0;
                    k_q             <= '0;
                end
                ST_MAC: begin
                    acc_q <= aluResult;
                    k_q   <= k_q + 1'b1;
                    // Final tap: publish so result is already valid while done is high.
                    if (k_q == K_LAST) result_q <= aluResult;
                end
                ST_DONE: head_q <= head_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a behavioural ALU in the loop.
module tb_fir_mac_sequencer;
    import fir_mac_sequencer_pkg::*;

    localparam int TAPS   = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       sampleIn = '0;
    logic              coeffWe = 1'b0;
    logic [ADDR_W-1:0] coeffAddr = '0;
    logic [31:0]       coeffData = '0;
    logic [31:0]       aluResult;
    logic [31:0]       aluIn1, aluIn2, aluAccum;
    logic [4:0]        aluOperation;
    logic [2:0]        aluControl;
    logic              busy, done;
    logic [31:0]       result;
    logic [31:0]       prod;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .sampleIn(sampleIn),
        .coeffWe(coeffWe), .coeffAddr(coeffAddr), .coeffData(coeffData),
        .aluResult(aluResult), .aluIn1(aluIn1), .aluIn2(aluIn2),
        .aluAccum(aluAccum), .aluOperation(aluOperation), .aluControl(aluControl),
        .busy(busy), .done(done), .result(result)
    );

    assign prod      = aluIn1 * aluIn2;
    assign aluResult = (aluOperation == ALU_OP_VMAC) ? aluAccum + (prod >> 15)
                                                     : aluIn1 + aluIn2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic write_coef(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        coeffWe = 1'b1; coeffAddr = a; coeffData = d;
        step();
        coeffWe = 1'b0;
    endtask

    // Waits for done; lat counts cycles since the start edge (LOAD = 1).
    task automatic wait_done(input int first, output logic [31:0] r, output int lat,
                             output int busy_cyc);
        r = '0; lat = -1; busy_cyc = 0;
        for (int c = first; c < first + 40; c++) begin
            if (busy) busy_cyc++;
            if (done) begin
                r = result; lat = c;
                break;
            end
            step();
        end
        if (lat < 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: no done pulse within 40 cycles, required one");
        end
        step();
    endtask

    task automatic run_sample(input logic [31:0] s, output logic [31:0] r,
                              output int lat, output int busy_cyc);
        start = 1'b1; sampleIn = s;
        step();
        start = 1'b0; coeffWe = 1'b0;
        wait_done(1, r, lat, busy_cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_vec++;
        if ({busy, done} !== 2'b00 || result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_status: busy=%b done=%b result=%0d, required 0 0 0",
                     busy, done, result);
        end
        n_vec++;
        if (aluIn1 !== 32'd0 || aluIn2 !== 32'd0 || aluAccum !== 32'd0) begin
            n_err++;
            $display("FAIL reset_alu_data: in1=%0d in2=%0d acc=%0d, required 0 0 0",
                     aluIn1, aluIn2, aluAccum);
        end
        n_vec++;
        if (aluOperation !== ALU_OP_ADD || aluControl !== ALU_CTRL_NOJUMP) begin
            n_err++;
            $display("FAIL reset_alu_ctrl: op=%0d ctrl=%0d, required %0d %0d",
                     aluOperation, aluControl, ALU_OP_ADD, ALU_CTRL_NOJUMP);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_zero_coeffs();
        logic [31:0] r; int lat, bc;
        do_reset();
        run_sample(32'd100, r, lat, bc);
        n_vec++;
        if (r !== 32'd0) begin
            n_err++; $display("FAIL zero_coef_result: got %0d, required 0", r);
        end
        n_vec++;
        if (lat !== TAPS + 2) begin
            n_err++; $display("FAIL done_latency: got %0d, required %0d", lat, TAPS + 2);
        end
        n_vec++;
        if (bc + 1 !== TAPS + 3) begin
            n_err++; $display("FAIL busy_window: got %0d, required %0d", bc + 1, TAPS + 3);
        end
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL after_done: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_h0_unity();
        logic [31:0] r; int lat, bc;
        do_reset();
        write_coef(3'd0, 32'd32768);
        run_sample(32'd100, r, lat, bc);
        n_vec++;
        if (r !== 32'd100) begin n_err++; $display("FAIL h0_first: got %0d, required 100", r); end
        run_sample(32'd200, r, lat, bc);
        n_vec++;
        if (r !== 32'd200) begin n_err++; $display("FAIL h0_second: got %0d, required 200", r); end
        n_vec++;
        if (result !== 32'd200) begin
            n_err++; $display("FAIL result_hold: got %0d, required 200", result);
        end
    endtask

    task automatic test_h1_half();
        logic [31:0] r; int lat, bc;
        logic [31:0] exp_r [3];
        logic [31:0] smp [3];
        exp_r = '{32'd0, 32'd50, 32'd100};
        smp   = '{32'd100, 32'd200, 32'd300};
        do_reset();
        write_coef(3'd1, 32'd16384);
        for (int i = 0; i < 3; i++) begin
            run_sample(smp[i], r, lat, bc);
            n_vec++;
            if (r !== exp_r[i]) begin
                n_err++; $display("FAIL h1_delay[%0d]: got %0d, required %0d", i, r, exp_r[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] r; int lat, bc;
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(ADDR_W'(k), 32'd32768);
        for (int i = 0; i < 10; i++) begin
            run_sample(32'd1, r, lat, bc);
            n_vec++;
            if (r !== ((i < 8) ? 32'(i + 1) : 32'd8)) begin
                n_err++; $display("FAIL wrap[%0d]: got %0d, required %0d", i, r,
                                  (i < 8) ? i + 1 : 8);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] r; int lat, bc;
        do_reset();
        write_coef(3'd0, 32'd32768);
        start = 1'b1; sampleIn = 32'd5;
        step();
        start = 1'b0;
        step();
        start = 1'b1; sampleIn = 32'd99;
        coeffWe = 1'b1; coeffAddr = 3'd0; coeffData = 32'd0;
        step();
        start = 1'b0; coeffWe = 1'b0;
        wait_done(3, r, lat, bc);
        n_vec++;
        if (r !== 32'd5) begin n_err++; $display("FAIL frozen_coef: got %0d, required 5", r); end
        step();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL no_restart: busy=%b, required 0", busy); end
        write_coef(3'd0, 32'd16384);
        run_sample(32'd10, r, lat, bc);
        n_vec++;
        if (r !== 32'd5) begin n_err++; $display("FAIL idle_coef_write: got %0d, required 5", r); end
        coeffWe = 1'b1; coeffAddr = 3'd0; coeffData = 32'd32768;
        run_sample(32'd4, r, lat, bc);
        n_vec++;
        if (r !== 32'd4) begin n_err++; $display("FAIL start_with_write: got %0d, required 4", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat, bc;
        int saw_done;
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(ADDR_W'(k), 32'd32768);
        run_sample(32'd50, r, lat, bc);
        n_vec++;
        if (r !== 32'd50) begin n_err++; $display("FAIL pre_reset_run: got %0d, required 50", r); end
        start = 1'b1; sampleIn = 32'd60;
        step();
        start = 1'b0;
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || result !== 32'd0 || done !== 1'b0) begin
            n_err++; $display("FAIL async_reset: busy=%b result=%0d done=%b, required 0 0 0",
                              busy, result, done);
        end
        step();
        reset = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) saw_done++;
            step();
        end
        n_vec++;
        if (saw_done !== 0) begin
            n_err++; $display("FAIL no_done_after_reset: got %0d pulses, required 0", saw_done);
        end
        for (int k = 0; k < TAPS; k++) write_coef(ADDR_W'(k), 32'd32768);
        run_sample(32'd7, r, lat, bc);
        n_vec++;
        if (r !== 32'd7) begin n_err++; $display("FAIL delay_cleared: got %0d, required 7", r); end
    endtask

    initial begin
        step();
        test_reset();
        test_zero_coeffs();
        test_h0_unity();
        test_h1_half();
        test_wrap();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
